mul_sequencer: RTL and testbench

//  Controller between the execute stage and the 9-cycle Multiplication unit (RV32M MUL/MULH/MULHSU/MULHU).

---
 rtl/mul_sequencer.sv | 112 +++++++++++
 tb/tb_mul_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: sequences RV32M multiplies through a 9-cycle multiplier with a one-entry operand cache
module mul_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_FUNCT3,
  input  logic [XLEN-1:0]   REQ_RS1,
  input  logic [XLEN-1:0]   REQ_RS2,
  input  logic [TAG_W-1:0]  REQ_TAG,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic [XLEN-1:0]   RESP_DATA,
  output logic [TAG_W-1:0]  RESP_TAG,
  output logic              MUL_START,
  output logic              MUL_STALL,
  output logic              MUL_SIGN1,
  output logic              MUL_SIGN2,
  output logic [XLEN-1:0]   MUL_MULTIPLIER,
  output logic [XLEN-1:0]   MUL_MULTIPLICAND,
  input  logic [2*XLEN-1:0] MUL_PRODUCT,
  input  logic              MUL_READY
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SETTLE, RESP} state_t;
  state_t state;
  logic [1:0] funct3_q;
  logic hit_q;
  logic c_valid, c_s1, c_s2;
  logic [XLEN-1:0] c_rs1, c_rs2;
  logic [2*XLEN-1:0] c_prod;
  logic req_s1, req_s2, hit;
  logic [2*XLEN-1:0] prod;
  assign req_s1 = REQ_FUNCT3 != 2'b11;
  assign req_s2 = !REQ_FUNCT3[1];
  // the low half is sign-independent, so MUL hits regardless of the cached signs
  assign hit = c_valid && REQ_RS1 == c_rs1 && REQ_RS2 == c_rs2 &&
               ((req_s1 == c_s1 && req_s2 == c_s2) || REQ_FUNCT3 == 2'b00);
  assign prod = hit_q ? c_prod : MUL_PRODUCT;
  assign REQ_READY = state == IDLE && !STALL && !FLUSH;
  assign MUL_STALL = STALL;
  // control FSM; a cache hit passes through SETTLE to form its result from the cached product
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      funct3_q         <= '0;
      hit_q            <= 1'b0;
      c_valid          <= 1'b0;
      c_s1             <= 1'b0;
      c_s2             <= 1'b0;
      c_rs1            <= '0;
      c_rs2            <= '0;
      c_prod           <= '0;
      RESP_VALID       <= 1'b0;
      RESP_DATA        <= '0;
      RESP_TAG         <= '0;
      MUL_START        <= 1'b0;
      MUL_SIGN1        <= 1'b0;
      MUL_SIGN2        <= 1'b0;
      MUL_MULTIPLIER   <= '0;
      MUL_MULTIPLICAND <= '0;
    end else if (FLUSH) begin
      state      <= IDLE;
      RESP_VALID <= 1'b0;
      MUL_START  <= 1'b0;
    end else if (!STALL) begin
      case (state)
        IDLE: if (REQ_VALID) begin
          RESP_TAG <= REQ_TAG;
          funct3_q <= REQ_FUNCT3;
          hit_q    <= hit;
          if (hit) state <= SETTLE;
          else begin
            MUL_MULTIPLIER   <= REQ_RS1;
            MUL_MULTIPLICAND <= REQ_RS2;
            MUL_SIGN1        <= req_s1;
            MUL_SIGN2        <= req_s2;
            MUL_START        <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          MUL_START <= 1'b0;
          state     <= WAIT;
        end
        WAIT: if (MUL_READY) state <= SETTLE;
        SETTLE: begin
          RESP_DATA  <= funct3_q == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          RESP_VALID <= 1'b1;
          state      <= RESP;
          if (!hit_q) begin
            c_valid <= 1'b1;
            c_rs1   <= MUL_MULTIPLIER;
            c_rs2   <= MUL_MULTIPLICAND;
            c_s1    <= MUL_SIGN1;
            c_s2    <= MUL_SIGN2;
            c_prod  <= MUL_PRODUCT;
          end
        end
        RESP: if (RESP_READY) begin
          RESP_VALID <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed checks of the multiply sequencer against a behavioural 9-cycle multiplier
module tb_mul_sequencer;
  logic CLK, RST, STALL, FLUSH, REQ_VALID, REQ_READY, RESP_VALID, RESP_READY;
  logic [1:0] REQ_FUNCT3;
  logic [31:0] REQ_RS1, REQ_RS2, RESP_DATA, MUL_MULTIPLIER, MUL_MULTIPLICAND;
  logic [4:0] REQ_TAG, RESP_TAG;
  logic MUL_START, MUL_STALL, MUL_SIGN1, MUL_SIGN2, MUL_READY;
  logic [63:0] MUL_PRODUCT;
  int vecs = 0;
  int errs = 0;

  mul_sequencer dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_FUNCT3(REQ_FUNCT3),
    .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_TAG(REQ_TAG),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA), .RESP_TAG(RESP_TAG),
    .MUL_START(MUL_START), .MUL_STALL(MUL_STALL), .MUL_SIGN1(MUL_SIGN1), .MUL_SIGN2(MUL_SIGN2),
    .MUL_MULTIPLIER(MUL_MULTIPLIER), .MUL_MULTIPLICAND(MUL_MULTIPLICAND),
    .MUL_PRODUCT(MUL_PRODUCT), .MUL_READY(MUL_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // multiplier model: READY drops after START, rises 9 unstalled edges later, PRODUCT_OUT one edge after that
  logic [63:0] pend;
  int cnt;
  logic rdy_q;
  initial begin
    MUL_READY = 1'b1;
    rdy_q = 1'b1;
    MUL_PRODUCT = '0;
    pend = '0;
    cnt = 0;
  end
  always @(posedge CLK) begin
    rdy_q <= MUL_READY;
    if (MUL_START && !MUL_STALL) begin
      cnt <= 9;
      MUL_READY <= 1'b0;
      pend <= {{32{MUL_SIGN1 & MUL_MULTIPLIER[31]}}, MUL_MULTIPLIER} *
              {{32{MUL_SIGN2 & MUL_MULTIPLICAND[31]}}, MUL_MULTIPLICAND};
    end else if (!MUL_READY && !MUL_STALL) begin
      cnt <= cnt - 1;
      if (cnt == 1) MUL_READY <= 1'b1;
    end
    if (MUL_READY && !rdy_q) MUL_PRODUCT <= pend;
  end

  task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    @(negedge CLK);
    REQ_FUNCT3 = f; REQ_RS1 = a; REQ_RS2 = b; REQ_TAG = t; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_resp(input int base, output int lat, output int starts);
    starts = int'(MUL_START);
    lat = -1;
    for (int n = base + 1; n <= base + 40 && lat < 0; n++) begin
      @(posedge CLK);
      #1;
      starts += int'(MUL_START);
      if (RESP_VALID) lat = n;
    end
  endtask

  task automatic take();
    @(negedge CLK);
    RESP_READY = 1'b1;
    @(posedge CLK);
    #1 RESP_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; STALL = 0; FLUSH = 0; REQ_VALID = 0; RESP_READY = 0;
    REQ_FUNCT3 = 0; REQ_RS1 = 0; REQ_RS2 = 0; REQ_TAG = 0;
    repeat (2) @(posedge CLK);
    #1;
    vecs++;
    if ({RESP_VALID, MUL_START, MUL_SIGN1, MUL_SIGN2} !== 4'b0 || RESP_DATA !== 0 || RESP_TAG !== 0 ||
        MUL_MULTIPLIER !== 0 || MUL_MULTIPLICAND !== 0) begin
      errs++;
      $display("FAIL reset_outputs: valid=%b start=%b data=%h tag=%h ops=%h/%h required all zero",
               RESP_VALID, MUL_START, RESP_DATA, RESP_TAG, MUL_MULTIPLIER, MUL_MULTIPLICAND);
    end
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK);
    #1;
    vecs++;
    if (REQ_READY !== 1'b1) begin errs++; $display("FAIL reset_req_ready: got %b required 1", REQ_READY); end
  endtask

  task automatic test_mulhu();
    int lat, st;
    send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
    vecs++;
    if (MUL_SIGN1 !== 0 || MUL_SIGN2 !== 0) begin errs++; $display("FAIL mulhu_signs: got %b%b required 00", MUL_SIGN1, MUL_SIGN2); end
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 12) begin errs++; $display("FAIL mulhu_latency: got %0d required 12", lat); end
    vecs++;
    if (st !== 1) begin errs++; $display("FAIL mulhu_starts: got %0d required 1", st); end
    vecs++;
    if (RESP_DATA !== 32'hFFFFFFFE || RESP_TAG !== 5'd1) begin
      errs++; $display("FAIL mulhu_data: got %h/%0d required fffffffe/1", RESP_DATA, RESP_TAG);
    end
    take();
  endtask

  task automatic test_cache_hit();
    int lat, st;
    send(2'b01, 32'hFFFFFFFE, 32'd7, 5'd2);
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 12 || RESP_DATA !== 32'hFFFFFFFF) begin
      errs++; $display("FAIL mulh_neg: lat %0d data %h required 12 ffffffff", lat, RESP_DATA);
    end
    take();
    send(2'b00, 32'hFFFFFFFE, 32'd7, 5'd3);
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 1 || st !== 0) begin errs++; $display("FAIL hit_latency: lat %0d starts %0d required 1 0", lat, st); end
    vecs++;
    if (RESP_DATA !== 32'hFFFFFFF2 || RESP_TAG !== 5'd3) begin
      errs++; $display("FAIL hit_data: got %h/%0d required fffffff2/3", RESP_DATA, RESP_TAG);
    end
    take();
  endtask

  task automatic test_sign_miss();
    int lat, st;
    send(2'b01, 32'h80000000, 32'h80000000, 5'd4);
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 12 || RESP_DATA !== 32'h40000000) begin
      errs++; $display("FAIL mulh_min: lat %0d data %h required 12 40000000", lat, RESP_DATA);
    end
    take();
    send(2'b10, 32'h80000000, 32'h80000000, 5'd5);
    vecs++;
    if (MUL_SIGN1 !== 1 || MUL_SIGN2 !== 0) begin errs++; $display("FAIL mulhsu_signs: got %b%b required 10", MUL_SIGN1, MUL_SIGN2); end
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 12 || st !== 1 || RESP_DATA !== 32'hC0000000) begin
      errs++; $display("FAIL mulhsu_miss: lat %0d starts %0d data %h required 12 1 c0000000", lat, st, RESP_DATA);
    end
    take();
  endtask

  task automatic test_backpressure();
    int lat, st;
    send(2'b10, 32'h80000000, 32'h80000000, 5'd6);
    wait_resp(0, lat, st);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      vecs++;
      if (RESP_VALID !== 1 || RESP_DATA !== 32'hC0000000 || RESP_TAG !== 5'd6 || REQ_READY !== 0) begin
        errs++; $display("FAIL hold_resp[%0d]: v=%b d=%h t=%0d rr=%b required 1 c0000000 6 0",
                         i, RESP_VALID, RESP_DATA, RESP_TAG, REQ_READY);
      end
    end
    take();
    vecs++;
    if (RESP_VALID !== 0 || REQ_READY !== 1) begin
      errs++; $display("FAIL release: valid %b req_ready %b required 0 1", RESP_VALID, REQ_READY);
    end
    send(2'b00, 32'h80000000, 32'h80000000, 5'd7);
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 1 || RESP_DATA !== 32'h0 || RESP_TAG !== 5'd7) begin
      errs++; $display("FAIL next_after_release: lat %0d data %h tag %0d required 1 0 7", lat, RESP_DATA, RESP_TAG);
    end
    take();
  endtask

  task automatic test_stall();
    int lat, st;
    send(2'b00, 32'h12345678, 32'h00000010, 5'd8);
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK) STALL = 1'b1;
    #1;
    vecs++;
    if (MUL_STALL !== 1) begin errs++; $display("FAIL mul_stall: got %b required 1", MUL_STALL); end
    repeat (3) @(posedge CLK);
    @(negedge CLK) STALL = 1'b0;
    wait_resp(6, lat, st);
    vecs++;
    if (lat !== 15 || RESP_DATA !== 32'h23456780 || RESP_TAG !== 5'd8) begin
      errs++; $display("FAIL stall_resp: lat %0d data %h tag %0d required 15 23456780 8", lat, RESP_DATA, RESP_TAG);
    end
    take();
  endtask

  task automatic test_flush();
    int lat, st;
    int seen = 0;
    send(2'b00, 32'd100, 32'd200, 5'd10);
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK) FLUSH = 1'b1;
    @(posedge CLK);
    #1 FLUSH = 1'b0;
    for (int i = 0; i < 15; i++) begin @(posedge CLK); #1; seen += int'(RESP_VALID); end
    vecs++;
    if (seen !== 0) begin errs++; $display("FAIL flush_drop: got %0d valid cycles required 0", seen); end
    @(negedge CLK) FLUSH = 1'b1;
    #1;
    vecs++;
    if (REQ_READY !== 0) begin errs++; $display("FAIL flush_blocks_req: got %b required 0", REQ_READY); end
    @(negedge CLK) FLUSH = 1'b0;
    send(2'b00, 32'd3, 32'd5, 5'd9);
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 12 || RESP_DATA !== 32'd15 || RESP_TAG !== 5'd9) begin
      errs++; $display("FAIL after_flush: lat %0d data %h tag %0d required 12 f 9", lat, RESP_DATA, RESP_TAG);
    end
    take();
  endtask

  task automatic test_reset_mid();
    int lat, st;
    send(2'b11, 32'hFFFFFFFF, 32'h2, 5'd11);
    repeat (4) begin @(posedge CLK); #1; end
    RST = 1'b1;
    #1;
    vecs++;
    if (RESP_VALID !== 0 || MUL_START !== 0 || MUL_MULTIPLIER !== 0 || REQ_READY !== 1) begin
      errs++; $display("FAIL mid_reset: v=%b s=%b op=%h rr=%b required 0 0 0 1", RESP_VALID, MUL_START, MUL_MULTIPLIER, REQ_READY);
    end
    @(negedge CLK) RST = 1'b0;
    send(2'b00, 32'd3, 32'd5, 5'd12);
    wait_resp(0, lat, st);
    vecs++;
    if (lat !== 12 || st !== 1 || RESP_DATA !== 32'd15) begin
      errs++; $display("FAIL cache_cleared: lat %0d starts %0d data %h required 12 1 f", lat, st, RESP_DATA);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_mulhu();
    test_cache_hit();
    test_sign_miss();
    test_backpressure();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
